useq_sequencer: RTL and testbench
=================================

Name: useq_sequencer

Overview:
- Microprogram sequencer; the reader side of the 23-bit control-memory ROM.
- Drives the ROM address, decodes each fetched word into a branch decision and a control vector, and steps through the microprogram; the Robertson multiplier microcode is the first client.
- Start/done handshake toward the host FSM.
- Status flags come from the datapath, e.g. multiplier LSB, counter zero.

Parameters:
- AW, 5, ROM address width.
- DW, 23, ROM word width.
- DEPTH, 18, number of valid ROM words; fetches at addresses >= DEPTH are errors.
- HALT_ADDR, 17, microaddress whose execution signals completion.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  level request from host; sampled in IDLE.
- stall  input  1  hold current microaddress for this cycle (RUN only).
- status  input  7  datapath condition flags, status[k] selects cond code k (k=1..7).
- rom_addr  output  AW  microaddress to ROM (= uPC).
- rom_data  input  DW  combinational ROM word for rom_addr.
- ctrl  output  15  control vector to datapath.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- err  output  1  sticky fetch-out-of-range flag, cleared on next accepted start.
- ucycles  output  8  count of executed (non-stalled) microinstructions, saturating at 255.

Behaviour:
- Word format:
  - rom_data[22:20] = cond select.
  - rom_data[19:15] = branch target.
  - rom_data[14:0] = control vector.
- Cond truth: code 0 is always true; code k (1..7) is status[k].
- Next address:
  - cond true -> target.
  - cond false -> uPC+1.
  - Addition is AW bits, no wrap allowed (see error rule).
- FSM: IDLE, RUN, DONE.
- Reset (async, reset_n low):
  - state=IDLE, uPC=0, ctrl=0, busy=0, done=0, err=0, ucycles=0.
  - Takes effect immediately, including mid-RUN.
- IDLE:
  - rom_addr=0, ctrl=0.
  - start=1 -> RUN next edge with uPC=0, ucycles=0, err=0.
- RUN:
  - ctrl = rom_data[14:0] combinationally from the current uPC; busy=1.
  - stall=1: uPC, ucycles and state hold; ctrl stays valid (datapath must gate its own enables).
  - stall=0 and uPC==HALT_ADDR: state->DONE (the halt word executes exactly once), ucycles+1.
  - stall=0 otherwise: uPC <= next address, ucycles+1 (saturating).
  - Error: computed next address >= DEPTH -> err=1, state->DONE, uPC unchanged.
- DONE:
  - ctrl=0, done=1, rom_addr holds the last uPC.
  - start=0 -> IDLE next edge. Start held high keeps DONE, so there is no auto-restart.
- Latency:
  - First microinstruction (addr 0) is presented the cycle after start is sampled.
  - One microinstruction per non-stalled cycle.
- start is ignored in RUN and DONE.
- status and stall are treated as synchronous to clk.

Test Plan:
- Unconditional chain: program the ROM with the multiplier microcode, status=0, start pulse. Required response:
  - rom_addr sequence 0,1,2,3,4,5,6,7,8,9,10,11,12,...,17.
  - done rises the cycle after addr 17.
  - ucycles equals the executed count.
  - ctrl at addr 0 = 15'b000000000000011.
- Taken branch:
  - status[1]=1 at addr 3 (word cond=1, target=12) -> next rom_addr=12.
  - status[2]=1 at addr 4 -> next 6.
- Stall: assert stall for 3 cycles at addr 5 -> rom_addr stays 5 for 4 cycles total, ucycles unchanged during the stall, then advances.
- Handshake: hold start=1 through completion -> stays DONE. Drop start -> IDLE next edge. Re-assert start -> restarts at 0 with ucycles=0.
- Error: word at DEPTH-1 with cond false and HALT_ADDR moved away -> err=1, done=1, ctrl=0. The next start clears err.
- Reset mid-run: pull reset_n low at addr 9 asynchronously. Required: all outputs zero and state IDLE immediately, before any clock edge.

Source files
------------

// File: rtl/useq_sequencer_if.sv
// rtl/useq_sequencer_if.sv - host/ROM/datapath signal bundle for the microprogram sequencer
interface useq_sequencer_if #(
    parameter int AW = 5,
    parameter int DW = 23
);
    logic          start;
    logic          stall;
    logic [7:1]    status;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [14:0]   ctrl;
    logic          busy;
    logic          done;
    logic          err;
    logic [7:0]    ucycles;

    // master: host, ROM and datapath side; slave: the sequencer itself
    modport master (
        output start, stall, status, rom_data,
        input  rom_addr, ctrl, busy, done, err, ucycles
    );

    modport slave (
        input  start, stall, status, rom_data,
        output rom_addr, ctrl, busy, done, err, ucycles
    );
endinterface

// File: rtl/useq_sequencer.sv
// rtl/useq_sequencer.sv - microprogram sequencer reading a 23-bit control-memory ROM
module useq_sequencer #(
    parameter int AW        = 5,
    parameter int DW        = 23,
    parameter int DEPTH     = 18,
    parameter int HALT_ADDR = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    useq_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] upc_q, upc_d;
    logic [7:0]    ucycles_q, ucycles_d;
    logic          err_q, err_d;

    logic [2:0]    cond_sel;
    logic [AW-1:0] target;
    logic [7:0]    cond_vec;
    logic          cond_true;
    logic [AW:0]   next_addr;
    logic          addr_err;
    logic          at_halt;
    logic [7:0]    ucycles_inc;

    assign cond_sel = bus.rom_data[DW-1 -: 3];
    assign target   = bus.rom_data[DW-4 -: AW];

    // code 0 maps onto the constant-one bit so it is always taken
    assign cond_vec  = {bus.status, 1'b1};
    assign cond_true = cond_vec[cond_sel];

    // one extra bit so uPC+1 past the top of the address space is still caught
    assign next_addr = cond_true ? {1'b0, target} : ({1'b0, upc_q} + {{AW{1'b0}}, 1'b1});
    assign addr_err  = (next_addr >= (AW+1)'(DEPTH));
    assign at_halt   = (upc_q == AW'(HALT_ADDR));

    assign ucycles_inc = (ucycles_q == 8'hFF) ? ucycles_q : (ucycles_q + 8'd1);

    always_comb begin
        state_d   = state_q;
        upc_d     = upc_q;
        ucycles_d = ucycles_q;
        err_d     = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_RUN;
                    upc_d     = '0;
                    ucycles_d = '0;
                    err_d     = 1'b0;
                end
            end
            S_RUN: begin
                if (!bus.stall) begin
                    ucycles_d = ucycles_inc;
                    if (at_halt) begin
                        state_d = S_DONE;
                    end else if (addr_err) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        upc_d = next_addr[AW-1:0];
                    end
                end
            end
            S_DONE: begin
                if (!bus.start) begin
                    state_d = S_IDLE;
                    upc_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                upc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            upc_q     <= '0;
            ucycles_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            upc_q     <= upc_d;
            ucycles_q <= ucycles_d;
            err_q     <= err_d;
        end
    end

    // outputs are decoded from state so an async reset clears them without waiting for a clock
    always_comb begin
        bus.rom_addr = upc_q;
        bus.ctrl     = '0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.err      = err_q;
        bus.ucycles  = ucycles_q;
        unique case (state_q)
            S_IDLE: bus.rom_addr = '0;
            S_RUN: begin
                bus.ctrl = bus.rom_data[14:0];
                bus.busy = 1'b1;
            end
            S_DONE:  bus.done = 1'b1;
            default: bus.rom_addr = '0;
        endcase
    end

endmodule

// File: tb/tb_useq_sequencer.sv
// tb/tb_useq_sequencer.sv - directed self-checking bench for useq_sequencer
module tb_useq_sequencer;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    logic [22:0] rom [0:17];
    logic [14:0] exp_ctrl [0:17];

    useq_sequencer_if #(.AW(5), .DW(23)) m_if ();
    useq_sequencer_if #(.AW(5), .DW(23)) e_if ();

    useq_sequencer #(.AW(5), .DW(23), .DEPTH(18), .HALT_ADDR(17)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (m_if.slave)
    );

    // halt moved out of reach so the last word falls through past DEPTH-1
    useq_sequencer #(.AW(5), .DW(23), .DEPTH(18), .HALT_ADDR(30)) dut_e (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (e_if.slave)
    );

    assign m_if.rom_data = (m_if.rom_addr < 5'd18) ? rom[m_if.rom_addr] : 23'd0;
    assign e_if.rom_data = (e_if.rom_addr == 5'd17) ? {3'd1, 5'd17, 15'h7FFF} :
                           (e_if.rom_addr < 5'd18) ? rom[e_if.rom_addr] : 23'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_addr(input logic [4:0] a, input string tag);
        int n;
        n = 0;
        while (m_if.rom_addr !== a && n < 40) begin
            step();
            n++;
        end
        total++;
        if (m_if.rom_addr !== a) begin
            bad++;
            $display("FAIL %s_reach_addr got=%0d want=%0d", tag, m_if.rom_addr, a);
        end
    endtask

    task automatic finish_run(input string tag);
        int n;
        n = 0;
        while (m_if.done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        total++;
        if (m_if.done !== 1'b1) begin
            bad++;
            $display("FAIL %s_done_timeout got=%b want=1", tag, m_if.done);
        end
        m_if.start = 1'b0;
        step();
    endtask

    task automatic load_rom();
        logic [2:0]  c [0:17];
        logic [4:0]  t [0:17];
        c = '{3'd0, 3'd0, 3'd3, 3'd1, 3'd2, 3'd0, 3'd4, 3'd0, 3'd5,
              3'd0, 3'd0, 3'd6, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0};
        t = '{5'd1, 5'd2, 5'd10, 5'd12, 5'd6, 5'd6, 5'd2, 5'd8, 5'd15,
              5'd10, 5'd11, 5'd4, 5'd13, 5'd16, 5'd15, 5'd16, 5'd17, 5'd17};
        exp_ctrl = '{15'h0003, 15'h0104, 15'h0008, 15'h0010, 15'h0020, 15'h0040,
                     15'h0080, 15'h0100, 15'h0200, 15'h0400, 15'h0800, 15'h1000,
                     15'h2000, 15'h4000, 15'h0001, 15'h0002, 15'h0005, 15'h7FFF};
        for (int i = 0; i < 18; i++) rom[i] = {c[i], t[i], exp_ctrl[i]};
    endtask

    task automatic test_reset();
        total++;
        if (m_if.rom_addr !== 5'd0 || m_if.ctrl !== 15'd0 || m_if.busy !== 1'b0 ||
            m_if.done !== 1'b0 || m_if.err !== 1'b0 || m_if.ucycles !== 8'd0) begin
            bad++;
            $display("FAIL reset_outputs got addr=%0d ctrl=%h busy=%b done=%b err=%b uc=%0d want all zero",
                     m_if.rom_addr, m_if.ctrl, m_if.busy, m_if.done, m_if.err, m_if.ucycles);
        end
        total++;
        if (e_if.busy !== 1'b0 || e_if.done !== 1'b0 || e_if.err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err_dut got busy=%b done=%b err=%b want 0", e_if.busy, e_if.done, e_if.err);
        end
    endtask

    task automatic test_chain();
        m_if.start = 1'b1;
        step();
        m_if.start = 1'b0;
        total++;
        if (m_if.ctrl !== 15'b000000000000011) begin
            bad++;
            $display("FAIL chain_ctrl0 got=%b want=000000000000011", m_if.ctrl);
        end
        for (int i = 0; i < 18; i++) begin
            total++;
            if (m_if.rom_addr !== i[4:0] || m_if.ucycles !== i[7:0] || m_if.busy !== 1'b1 ||
                m_if.ctrl !== exp_ctrl[i]) begin
                bad++;
                $display("FAIL chain_step%0d got addr=%0d uc=%0d busy=%b ctrl=%h want addr=%0d uc=%0d busy=1 ctrl=%h",
                         i, m_if.rom_addr, m_if.ucycles, m_if.busy, m_if.ctrl, i, i, exp_ctrl[i]);
            end
            step();
        end
        total++;
        if (m_if.done !== 1'b1 || m_if.busy !== 1'b0 || m_if.ucycles !== 8'd18 ||
            m_if.ctrl !== 15'd0 || m_if.rom_addr !== 5'd17 || m_if.err !== 1'b0) begin
            bad++;
            $display("FAIL chain_done got done=%b busy=%b uc=%0d ctrl=%h addr=%0d err=%b want 1 0 18 0 17 0",
                     m_if.done, m_if.busy, m_if.ucycles, m_if.ctrl, m_if.rom_addr, m_if.err);
        end
        step();
        total++;
        if (m_if.done !== 1'b0 || m_if.rom_addr !== 5'd0 || m_if.ucycles !== 8'd18) begin
            bad++;
            $display("FAIL chain_idle got done=%b addr=%0d uc=%0d want 0 0 18",
                     m_if.done, m_if.rom_addr, m_if.ucycles);
        end
    endtask

    task automatic test_branch();
        m_if.start = 1'b1;
        step();
        m_if.start = 1'b0;
        wait_addr(5'd3, "br1");
        m_if.status = 7'b0000001;
        step();
        m_if.status = 7'b0;
        total++;
        if (m_if.rom_addr !== 5'd12 || m_if.ucycles !== 8'd4) begin
            bad++;
            $display("FAIL branch_cond1 got addr=%0d uc=%0d want 12 4", m_if.rom_addr, m_if.ucycles);
        end
        finish_run("br1");

        m_if.start = 1'b1;
        step();
        m_if.start = 1'b0;
        wait_addr(5'd4, "br2");
        m_if.status = 7'b0000010;
        step();
        m_if.status = 7'b0;
        total++;
        if (m_if.rom_addr !== 5'd6 || m_if.ucycles !== 8'd5) begin
            bad++;
            $display("FAIL branch_cond2 got addr=%0d uc=%0d want 6 5", m_if.rom_addr, m_if.ucycles);
        end
        finish_run("br2");
    endtask

    task automatic test_stall();
        m_if.start = 1'b1;
        step();
        m_if.start = 1'b0;
        wait_addr(5'd5, "stall");
        m_if.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (m_if.rom_addr !== 5'd5 || m_if.ucycles !== 8'd5 || m_if.ctrl !== 15'h0040) begin
                bad++;
                $display("FAIL stall_hold%0d got addr=%0d uc=%0d ctrl=%h want 5 5 0040",
                         k, m_if.rom_addr, m_if.ucycles, m_if.ctrl);
            end
        end
        m_if.stall = 1'b0;
        step();
        total++;
        if (m_if.rom_addr !== 5'd6 || m_if.ucycles !== 8'd6) begin
            bad++;
            $display("FAIL stall_release got addr=%0d uc=%0d want 6 6", m_if.rom_addr, m_if.ucycles);
        end
        finish_run("stall");
    endtask

    task automatic test_handshake();
        int n;
        m_if.start = 1'b1;
        n = 0;
        step();
        while (m_if.done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        step();
        step();
        total++;
        if (m_if.done !== 1'b1 || m_if.busy !== 1'b0 || m_if.rom_addr !== 5'd17) begin
            bad++;
            $display("FAIL hs_hold_done got done=%b busy=%b addr=%0d want 1 0 17",
                     m_if.done, m_if.busy, m_if.rom_addr);
        end
        m_if.start = 1'b0;
        step();
        total++;
        if (m_if.done !== 1'b0 || m_if.busy !== 1'b0 || m_if.rom_addr !== 5'd0) begin
            bad++;
            $display("FAIL hs_idle got done=%b busy=%b addr=%0d want 0 0 0",
                     m_if.done, m_if.busy, m_if.rom_addr);
        end
        m_if.start = 1'b1;
        step();
        total++;
        if (m_if.busy !== 1'b1 || m_if.rom_addr !== 5'd0 || m_if.ucycles !== 8'd0) begin
            bad++;
            $display("FAIL hs_restart got busy=%b addr=%0d uc=%0d want 1 0 0",
                     m_if.busy, m_if.rom_addr, m_if.ucycles);
        end
        finish_run("hs");
    endtask

    task automatic test_error();
        int n;
        e_if.start = 1'b1;
        step();
        e_if.start = 1'b0;
        n = 0;
        while (e_if.done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        total++;
        if (e_if.err !== 1'b1 || e_if.done !== 1'b1 || e_if.ctrl !== 15'd0 ||
            e_if.rom_addr !== 5'd17 || e_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL err_flag got err=%b done=%b ctrl=%h addr=%0d busy=%b want 1 1 0 17 0",
                     e_if.err, e_if.done, e_if.ctrl, e_if.rom_addr, e_if.busy);
        end
        step();
        total++;
        if (e_if.err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky got=%b want=1", e_if.err);
        end
        e_if.start = 1'b1;
        step();
        e_if.start = 1'b0;
        total++;
        if (e_if.err !== 1'b0 || e_if.busy !== 1'b1 || e_if.rom_addr !== 5'd0) begin
            bad++;
            $display("FAIL err_clear got err=%b busy=%b addr=%0d want 0 1 0",
                     e_if.err, e_if.busy, e_if.rom_addr);
        end
    endtask

    task automatic test_reset_midrun();
        m_if.start = 1'b1;
        step();
        m_if.start = 1'b0;
        wait_addr(5'd9, "rst");
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (m_if.rom_addr !== 5'd0 || m_if.ctrl !== 15'd0 || m_if.busy !== 1'b0 ||
            m_if.done !== 1'b0 || m_if.err !== 1'b0 || m_if.ucycles !== 8'd0) begin
            bad++;
            $display("FAIL reset_async got addr=%0d ctrl=%h busy=%b done=%b err=%b uc=%0d want all zero",
                     m_if.rom_addr, m_if.ctrl, m_if.busy, m_if.done, m_if.err, m_if.ucycles);
        end
        step();
        reset_n = 1'b1;
        step();
        total++;
        if (m_if.busy !== 1'b0 || m_if.rom_addr !== 5'd0) begin
            bad++;
            $display("FAIL reset_stays_idle got busy=%b addr=%0d want 0 0", m_if.busy, m_if.rom_addr);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        m_if.start = 1'b0;
        m_if.stall = 1'b0;
        m_if.status = 7'b0;
        e_if.start = 1'b0;
        e_if.stall = 1'b0;
        e_if.status = 7'b0;
        load_rom();
        #1;
        test_reset();
        step();
        step();
        reset_n = 1'b1;
        step();
        test_chain();
        test_branch();
        test_stall();
        test_handshake();
        test_error();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
